// File: rtl/usart_rx_controller.sv
// USART receive controller: runs the receiver handshake on comm_clock,
// buffers good bytes in a FIFO and keeps sticky error flags and counts.
module usart_rx_controller #(
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  comm_clock,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  flush,
   input  logic                  clear_status,
   input  logic [7:0]            rx_data,
   input  logic                  rx_available,
   input  logic                  rx_error,
   output logic                  rx_acknowledge,
   output logic [7:0]            rd_data,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [ADDR_WIDTH:0]   level,
   output logic                  full,
   output logic                  overrun,
   output logic                  framing,
   output logic [7:0]            overrun_count,
   output logic [7:0]            framing_count
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] FULL_LEVEL = {1'b1, {ADDR_WIDTH{1'b0}}};

   localparam logic [0:0] IDLE     = 1'b0;
   localparam logic [0:0] ACK_WAIT = 1'b1;

   logic [0:0]            state;
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [7:0]            mem [DEPTH];

   logic take_byte;
   logic take_error;
   logic pop;
   logic push_req;
   logic push_ok;
   logic drop;

   assign take_byte  = (state == IDLE) && rx_available;
   assign take_error = (state == IDLE) && !rx_available && rx_error;
   assign pop        = rd_valid && rd_ready;
   assign push_req   = take_byte && enable;
   // A full FIFO still accepts a byte when the head leaves on the same edge.
   assign push_ok    = push_req && (!full || pop) && !flush;
   // A byte taken during a flush is thrown away, not reported as overrun.
   assign drop       = push_req && full && !pop && !flush;

   assign full     = (level == FULL_LEVEL);
   assign rd_valid = (level != '0);
   assign rd_data  = mem[rd_ptr];

   // Receiver handshake: acknowledge a frame, hold until the receiver idles.
   always_ff @(posedge comm_clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         rx_acknowledge <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (rx_available || rx_error) begin
                  state          <= ACK_WAIT;
                  rx_acknowledge <= 1'b1;
               end
            end
            default: begin
               if (!rx_available && !rx_error) begin
                  state          <= IDLE;
                  rx_acknowledge <= 1'b0;
               end
            end
         endcase
      end
   end

   // FIFO storage; contents are don't-care until written.
   always_ff @(posedge comm_clock) begin
      if (push_ok)
         mem[wr_ptr] <= rx_data;
   end

   // FIFO pointers and occupancy, flush overriding push and pop.
   always_ff @(posedge comm_clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         if (pop)
            rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
         if (push_ok && !pop)
            level <= level + (ADDR_WIDTH+1)'(1);
         else if (pop && !push_ok)
            level <= level - (ADDR_WIDTH+1)'(1);
      end
   end

   // Sticky error flags and saturating counters; clear beats a new event.
   always_ff @(posedge comm_clock or negedge reset) begin
      if (!reset) begin
         overrun       <= 1'b0;
         framing       <= 1'b0;
         overrun_count <= 8'd0;
         framing_count <= 8'd0;
      end else if (clear_status) begin
         overrun       <= 1'b0;
         framing       <= 1'b0;
         overrun_count <= 8'd0;
         framing_count <= 8'd0;
      end else begin
         if (drop) begin
            overrun <= 1'b1;
            if (overrun_count != 8'hFF)
               overrun_count <= overrun_count + 8'd1;
         end
         if (take_error && enable) begin
            framing <= 1'b1;
            if (framing_count != 8'hFF)
               framing_count <= framing_count + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_usart_rx_controller.sv
// Self-checking bench for usart_rx_controller with a queue-based
// reference model of the FIFO, status flags and handshake.
module tb_usart_rx_controller;

   localparam int AW    = 2;
   localparam int DEPTH = 1 << AW;

   logic          comm_clock = 1'b0;
   logic          reset = 1'b0;
   logic          enable = 1'b1;
   logic          flush = 1'b0;
   logic          clear_status = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_available = 1'b0;
   logic          rx_error = 1'b0;
   logic          rx_acknowledge;
   logic [7:0]    rd_data;
   logic          rd_valid;
   logic          rd_ready = 1'b0;
   logic [AW:0]   level;
   logic          full;
   logic          overrun;
   logic          framing;
   logic [7:0]    overrun_count;
   logic [7:0]    framing_count;

   usart_rx_controller #(.ADDR_WIDTH(AW)) dut (
      .comm_clock     (comm_clock),
      .reset          (reset),
      .enable         (enable),
      .flush          (flush),
      .clear_status   (clear_status),
      .rx_data        (rx_data),
      .rx_available   (rx_available),
      .rx_error       (rx_error),
      .rx_acknowledge (rx_acknowledge),
      .rd_data        (rd_data),
      .rd_valid       (rd_valid),
      .rd_ready       (rd_ready),
      .level          (level),
      .full           (full),
      .overrun        (overrun),
      .framing        (framing),
      .overrun_count  (overrun_count),
      .framing_count  (framing_count)
   );

   always #5 comm_clock = ~comm_clock;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [7:0] q[$];
   bit         busy;
   bit         m_ack;
   bit         m_ovr;
   bit         m_frm;
   int         m_ovr_cnt;
   int         m_frm_cnt;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      busy      = 1'b0;
      m_ack     = 1'b0;
      m_ovr     = 1'b0;
      m_frm     = 1'b0;
      m_ovr_cnt = 0;
      m_frm_cnt = 0;
   endtask

   // One clock edge of the specified behaviour, in queue terms.
   task automatic model_edge();
      bit take_g, take_e, popped, ov, fr;
      take_g = !busy && rx_available;
      take_e = !busy && !rx_available && rx_error;
      popped = rd_ready && (q.size() > 0);
      ov = 1'b0;
      fr = 1'b0;
      if (flush) begin
         q.delete();
      end else begin
         if (popped)
            void'(q.pop_front());
         if (take_g && enable) begin
            if (q.size() < DEPTH)
               q.push_back(rx_data);
            else
               ov = 1'b1;
         end
      end
      if (take_e && enable)
         fr = 1'b1;
      if (clear_status) begin
         m_ovr = 0; m_frm = 0; m_ovr_cnt = 0; m_frm_cnt = 0;
      end else begin
         if (ov) begin
            m_ovr = 1'b1;
            if (m_ovr_cnt < 255) m_ovr_cnt++;
         end
         if (fr) begin
            m_frm = 1'b1;
            if (m_frm_cnt < 255) m_frm_cnt++;
         end
      end
      busy  = rx_available || rx_error;
      m_ack = busy;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".ack"}, 32'(rx_acknowledge), 32'(m_ack));
      chk({tag, ".valid"}, 32'(rd_valid), 32'(q.size() != 0));
      chk({tag, ".level"}, 32'(level), 32'(q.size()));
      chk({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
      chk({tag, ".ovr"}, 32'(overrun), 32'(m_ovr));
      chk({tag, ".frm"}, 32'(framing), 32'(m_frm));
      chk({tag, ".ovr_cnt"}, 32'(overrun_count), 32'(m_ovr_cnt));
      chk({tag, ".frm_cnt"}, 32'(framing_count), 32'(m_frm_cnt));
      if (q.size() != 0)
         chk({tag, ".data"}, 32'(rd_data), 32'(q[0]));
   endtask

   // Drive inputs for one cycle, step the model on the edge, then check.
   task automatic cyc(input string tag, input bit av, input bit er,
                      input logic [7:0] d, input bit rdy,
                      input bit fl, input bit clr);
      rx_available = av;
      rx_error     = er;
      rx_data      = d;
      rd_ready     = rdy;
      flush        = fl;
      clear_status = clr;
      @(posedge comm_clock);
      model_edge();
      #1;
      check_all(tag);
   endtask

   task automatic frame(input string tag, input logic [7:0] d,
                        input bit rdy);
      cyc(tag, 1, 0, d, rdy, 0, 0);
      cyc(tag, 0, 0, d, 0, 0, 0);
   endtask

   task automatic err_frame(input string tag);
      cyc(tag, 0, 1, 8'h00, 0, 0, 0);
      cyc(tag, 0, 0, 8'h00, 0, 0, 0);
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      model_reset();
      #3;
      check_all("reset");
      @(posedge comm_clock);
      #1;
      reset = 1'b1;
      cyc("idle", 0, 0, 8'h00, 0, 0, 0);

      // single byte, receiver holds available for two cycles
      cyc("b5a_take", 1, 0, 8'h5A, 0, 0, 0);
      cyc("b5a_hold", 1, 0, 8'h5A, 0, 0, 0);
      cyc("b5a_rel", 0, 0, 8'h00, 0, 0, 0);
      cyc("b5a_pop", 0, 0, 8'h00, 1, 0, 0);

      // fill, overrun, drain
      for (int i = 1; i <= 4; i++)
         frame("fill", 8'(i), 0);
      frame("ovr5", 8'h05, 0);
      for (int i = 0; i < 4; i++)
         cyc("drain", 0, 0, 8'h00, 1, 0, 0);
      cyc("empty_rdy", 0, 0, 8'h00, 1, 0, 0);

      // full FIFO with push and pop on the same edge
      for (int i = 0; i < 4; i++)
         frame("refill", 8'h10 + 8'(i), 0);
      frame("push_pop", 8'h77, 1);
      for (int i = 0; i < 4; i++)
         cyc("drain77", 0, 0, 8'h00, 1, 0, 0);

      // framing error and clear
      cyc("clr0", 0, 0, 8'h00, 0, 0, 1);
      err_frame("err1");
      cyc("clr1", 0, 0, 8'h00, 0, 0, 1);

      // saturation of framing_count
      for (int i = 0; i < 300; i++)
         err_frame("err_sat");
      cyc("clr2", 0, 0, 8'h00, 0, 0, 1);

      // discard while disabled
      enable = 1'b0;
      frame("dis", 8'hAA, 0);
      err_frame("dis_err");
      enable = 1'b1;

      // flush with level 3 and a frame arriving on the same edge
      for (int i = 0; i < 3; i++)
         frame("pre_flush", 8'h30 + 8'(i), 0);
      cyc("flush", 1, 0, 8'hEE, 0, 1, 0);
      cyc("flush_rel", 0, 0, 8'h00, 0, 0, 0);

      // clear colliding with an overrun event
      for (int i = 0; i < 4; i++)
         frame("fill_c", 8'h40 + 8'(i), 0);
      cyc("ovr_clr", 1, 0, 8'h99, 0, 0, 1);
      cyc("ovr_clr_rel", 0, 0, 8'h00, 0, 1, 0);

      // randomized traffic
      for (int i = 0; i < 600; i++) begin
         enable = ($urandom_range(0, 9) != 0);
         cyc("rand",
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 7) == 0,
             8'($urandom),
             $urandom_range(0, 2) == 0,
             $urandom_range(0, 40) == 0,
             $urandom_range(0, 60) == 0);
      end
      enable = 1'b1;
      cyc("rand_end", 0, 0, 8'h00, 0, 1, 1);

      // asynchronous reset while waiting for the receiver to idle
      frame("pre_rst", 8'h61, 0);
      cyc("ack_wait", 1, 0, 8'h62, 0, 0, 0);
      #2;
      reset = 1'b0;
      #1;
      chk("arst.ack", 32'(rx_acknowledge), 32'd0);
      chk("arst.level", 32'(level), 32'd0);
      chk("arst.valid", 32'(rd_valid), 32'd0);
      chk("arst.full", 32'(full), 32'd0);
      model_reset();
      rx_available = 1'b0;
      @(posedge comm_clock);
      #1;
      reset = 1'b1;
      cyc("post_rst", 0, 0, 8'h00, 0, 0, 0);
      frame("post_rst_b", 8'hC3, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/usart_rx_controller.md
Name: usart_rx_controller

Overview:
- Sits on the comm_clock side of the USART receiver and sequences its available/error/acknowledge handshake.
- Buffers good bytes in a FIFO of 2**ADDR_WIDTH entries.
- Counts framing and overrun errors.
- Presents a ready/valid read port plus status to the CPU bus glue, so the CPU never services the receiver handshake directly.

Parameters:
- ADDR_WIDTH, 4: FIFO depth is 2**ADDR_WIDTH bytes; legal values are 1..8.

Ports:
- comm_clock  input  1  system clock; all logic on its rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- enable  input  1  1 = store received bytes; 0 = acknowledge and discard every frame
- flush  input  1  synchronous FIFO clear
- clear_status  input  1  clears sticky flags and both counters
- rx_data  input  8  byte from the receiver
- rx_available  input  1  receiver reports a good frame
- rx_error  input  1  receiver reports a framing error
- rx_acknowledge  output  1  acknowledge to the receiver
- rd_data  output  8  byte at the FIFO head
- rd_valid  output  1  FIFO not empty
- rd_ready  input  1  consumer pops the head when rd_valid=1
- level  output  ADDR_WIDTH+1  FIFO occupancy, 0..2**ADDR_WIDTH
- full  output  1  level == 2**ADDR_WIDTH
- overrun  output  1  sticky: a good byte was dropped because the FIFO was full
- framing  output  1  sticky: an error frame was seen
- overrun_count  output  8  saturating count of dropped bytes
- framing_count  output  8  saturating count of error frames

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rx_acknowledge=0.
  - Read and write pointers=0; level=0; rd_valid=0; full=0.
  - overrun=0, framing=0, both counts=0.
  - rd_data is a don't-care while rd_valid=0.
- State machine: two states, IDLE and ACK_WAIT.
  - IDLE with rx_available=1 (checked before rx_error): take the byte on this edge, go to ACK_WAIT, set rx_acknowledge=1 (registered, so it is seen one cycle later).
  - IDLE with rx_available=0 and rx_error=1: go to ACK_WAIT, set rx_acknowledge=1. If enable=1, framing<=1 and framing_count increments, saturating at 255.
  - ACK_WAIT: hold rx_acknowledge=1 until rx_available=0 and rx_error=0 are seen together. On that edge: rx_acknowledge<=0, state<=IDLE.
  - No frame is taken while in ACK_WAIT, so each frame is counted exactly once.
- Taking a byte (IDLE, rx_available=1):
  - enable=0: discard the byte; no counters change.
  - enable=1 and push permitted: write rx_data at the write pointer, advance the pointer.
  - Push is permitted when full=0, or when a pop happens on the same edge. A full FIFO with a simultaneous pop therefore accepts the byte and level stays at the maximum.
  - enable=1 and push not permitted: drop the byte; overrun<=1; overrun_count increments, saturating at 255.
- Read port:
  - rd_data = mem[read pointer], combinational from the registered pointer.
  - Pop happens when rd_valid & rd_ready: read pointer advances, level decrements.
  - rd_ready while empty is ignored.
  - A byte written on edge N is visible with rd_valid=1 after edge N, i.e. one cycle of latency from the take to rd_valid.
- Pointers are ADDR_WIDTH bits and wrap modulo depth. level is computed at ADDR_WIDTH+1 bits. Push and pop on the same edge leave level unchanged.
- flush=1:
  - Pointers<=0, level<=0.
  - Flush takes priority over a simultaneous push and pop. A byte taken in that cycle is discarded and does not count as an overrun.
  - The handshake state machine is unaffected by flush.
- clear_status=1: overrun, framing and both counts <=0. If an error event occurs on the same edge, clear wins and the event is lost.
- enable changes take effect for the next frame taken; frames already stored stay in the FIFO.

Test Plan:
- Reset, then rx_available pulse with rx_data=0x5A (enable=1) -> rx_acknowledge=1 next cycle and held until rx_available=0; rd_valid=1, rd_data=0x5A, level=1; rd_ready for one cycle -> level=0, rd_valid=0.
- ADDR_WIDTH=2: push 0x01..0x04 -> full=1, level=4; fifth frame 0x05 -> overrun=1, overrun_count=1; pop all -> 0x01,0x02,0x03,0x04 in order.
- Full FIFO, frame 0x77 arrives on the same edge as rd_ready -> no overrun, level stays 4, last entry read out is 0x77.
- rx_error pulse, with rx_available=0 -> framing=1, framing_count=1, level unchanged, handshake completes; then clear_status -> all status and counts 0.
- 300 error frames -> framing_count saturates at 255.
- enable=0 frame -> acknowledged, level=0, counts 0. flush asserted while level=3 and a frame arrives the same cycle -> level=0, overrun=0.
- reset driven low while in ACK_WAIT with level=2 -> rx_acknowledge=0 and level=0 immediately, without waiting for a clock edge.
